// File: rtl/cr16_pkg.sv
// -----------------------------------------------------------------------------
// cr16_pkg
// Shared definitions for the CR16-subset multicycle controller:
//   - controller state encoding (state_t)
//   - opcode / extended-opcode constants of the instruction subset
//   - branch/jump condition-code constants
//   - select encodings for the pc_s, wd_s and alua_s datapath muxes
//   - small decode helpers used by the controller's dispatch logic
// Instruction fields: op=[15:12], Rdest/cond=[11:8], ext=[7:4], Rsrc/imm=[3:0].
// -----------------------------------------------------------------------------
package cr16_pkg;

  localparam int CR16_WIDTH     = 16;
  localparam int CR16_STATEBITS = 4;

  typedef enum logic [CR16_STATEBITS-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EX_R   = 4'd2,
    S_EX_I   = 4'd3,
    S_EX_SH  = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WB = 4'd6,
    S_MEM_WR = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  // Primary opcodes (instr[15:12]). The ALU codes double as the ext field
  // of the register-register forms under OP_RTYPE.
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_AND   = 4'b0001;
  localparam logic [3:0] OP_OR    = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_ADD   = 4'b0101;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_SUB   = 4'b1001;
  localparam logic [3:0] OP_CMP   = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOV   = 4'b1101;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  // Extended opcodes under OP_MEM.
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  // Condition codes carried in the Rdest field of Bcond/Jcond.
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_HI = 4'b0100;
  localparam logic [3:0] COND_LS = 4'b0101;
  localparam logic [3:0] COND_GT = 4'b0110;
  localparam logic [3:0] COND_LE = 4'b0111;
  localparam logic [3:0] COND_FS = 4'b1000;
  localparam logic [3:0] COND_FC = 4'b1001;
  localparam logic [3:0] COND_LO = 4'b1010;
  localparam logic [3:0] COND_HS = 4'b1011;
  localparam logic [3:0] COND_LT = 4'b1100;
  localparam logic [3:0] COND_GE = 4'b1101;
  localparam logic [3:0] COND_UC = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Flag bit positions inside flags[4:0] = {N,Z,F,L,C}.
  localparam int FLAG_N = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_L = 1;
  localparam int FLAG_C = 0;

  // Datapath select encodings.
  localparam logic [1:0] PC_INC    = 2'd0;  // pc + 1
  localparam logic [1:0] PC_DISP   = 2'd1;  // pc + sext(disp8)
  localparam logic [1:0] PC_REG    = 2'd2;  // Rsrc
  localparam logic [1:0] WD_ALU    = 2'd0;
  localparam logic [1:0] WD_MEM    = 2'd1;
  localparam logic [1:0] WD_LINK   = 2'd2;
  localparam logic [1:0] ALUA_RDEST = 2'd0;
  localparam logic [1:0] ALUA_PC    = 2'd1;
  localparam logic [1:0] ALUA_ZERO  = 2'd2;

  // ALU function codes shared by the R-type ext field and the I-type op.
  function automatic logic is_alu_code(input logic [3:0] code);
    logic hit;
    hit = 1'b0;
    case (code)
      OP_ADD, OP_SUB, OP_CMP, OP_AND, OP_OR, OP_XOR, OP_MOV: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Arithmetic forms are the only ones that update the PSR.
  function automatic logic sets_psr(input logic [3:0] code);
    return (code == OP_ADD) || (code == OP_SUB) || (code == OP_CMP);
  endfunction

  // Logical immediates take a zero-extended imm8.
  function automatic logic is_logical(input logic [3:0] code);
    return (code == OP_AND) || (code == OP_OR) || (code == OP_XOR);
  endfunction

  // DECODE dispatch: maps op/ext onto the first execution state.
  function automatic state_t dispatch(input logic [3:0] op, input logic [3:0] ext);
    state_t nxt;
    nxt = S_TRAP;
    if (op == OP_RTYPE) begin
      nxt = is_alu_code(ext) ? S_EX_R : S_TRAP;
    end else if (is_alu_code(op) || (op == OP_LUI)) begin
      nxt = S_EX_I;
    end else begin
      case (op)
        OP_SHIFT: nxt = S_EX_SH;
        OP_BCOND: nxt = S_BRANCH;
        OP_MEM: begin
          case (ext)
            EXT_LOAD:           nxt = S_MEM_RD;
            EXT_STOR:           nxt = S_MEM_WR;
            EXT_JCOND, EXT_JAL: nxt = S_JUMP;
            default:            nxt = S_TRAP;
          endcase
        end
        default: nxt = S_TRAP;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/cr16_cond_eval.sv
// -----------------------------------------------------------------------------
// cr16_cond_eval
// Purely combinational condition evaluator for Bcond/Jcond.
// Ports:
//   cond      in  4  condition code (Rdest field of the branch/jump)
//   flags     in  5  PSR {N,Z,F,L,C}
//   cond_true out 1  1 when the selected condition holds
// -----------------------------------------------------------------------------
module cr16_cond_eval
  import cr16_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       cond_true
);

  logic n_flag;
  logic z_flag;
  logic f_flag;
  logic l_flag;
  logic c_flag;

  assign n_flag = flags[FLAG_N];
  assign z_flag = flags[FLAG_Z];
  assign f_flag = flags[FLAG_F];
  assign l_flag = flags[FLAG_L];
  assign c_flag = flags[FLAG_C];

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_EQ: cond_true = z_flag;
      COND_NE: cond_true = ~z_flag;
      COND_CS: cond_true = c_flag;
      COND_CC: cond_true = ~c_flag;
      COND_HI: cond_true = l_flag;
      COND_LS: cond_true = ~l_flag;
      COND_GT: cond_true = n_flag;
      COND_LE: cond_true = ~n_flag;
      COND_FS: cond_true = f_flag;
      COND_FC: cond_true = ~f_flag;
      COND_LO: cond_true = ~l_flag & ~z_flag;
      COND_HS: cond_true = l_flag | z_flag;
      COND_LT: cond_true = ~n_flag & ~z_flag;
      COND_GE: cond_true = n_flag | z_flag;
      COND_UC: cond_true = 1'b1;
      COND_NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/cr16_controller.sv
// -----------------------------------------------------------------------------
// cr16_controller
// Multicycle control FSM for the 16-bit CR16-subset datapath. Sequences
// FETCH -> DECODE -> execute/memory/branch/jump/trap -> FETCH and drives
// every datapath select and enable.
//
// Build option: define MEM_READY_EN to add the mem_ready handshake input.
// FETCH, MEM_RD and MEM_WR then hold until mem_ready=1; only the address
// select stays driven while waiting, and ir_en/pcen/mem_we fire in the
// ready cycle. Without it memory is single-cycle.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   instr[15:0]           IR contents (op, Rdest/cond, ext, Rsrc/imm)
//   flags[4:0]            PSR {N,Z,F,L,C}
//   mem_ready             (MEM_READY_EN only) memory handshake
//   ir_en, pcen, pc_s     IR load, PC write and next-PC select
//   adr_s, mem_we         memory address select and write strobe
//   regwrite, wa_s, wd_s  register write enable, address and data select
//   alua_s, shft_s        ALU A/B operand selects
//   imm_sext              imm8 sign (1) or zero (0) extension
//   alu_op                ALU function code
//   psr_en                PSR update enable
//   illegal               one-cycle pulse on an undecodable instruction
// -----------------------------------------------------------------------------
module cr16_controller
  import cr16_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int STATEBITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] instr,
  input  logic [4:0]       flags,
`ifdef MEM_READY_EN
  input  logic             mem_ready,
`endif
  output logic             ir_en,
  output logic             pcen,
  output logic [1:0]       pc_s,
  output logic             adr_s,
  output logic             mem_we,
  output logic             regwrite,
  output logic             wa_s,
  output logic [1:0]       wd_s,
  output logic [1:0]       alua_s,
  output logic             shft_s,
  output logic             imm_sext,
  output logic [3:0]       alu_op,
  output logic             psr_en,
  output logic             illegal
);

  // Only the 16-bit instruction format and the package state width exist.
  if ((WIDTH != CR16_WIDTH) || (STATEBITS != CR16_STATEBITS)) begin : g_bad_cfg
    $error("cr16_controller: unsupported WIDTH/STATEBITS");
  end

  state_t     state_reg;
  logic [3:0] op;
  logic [3:0] ext;
  logic [3:0] cond;
  logic [3:0] alu_code;
  logic       cond_true;
  logic       mem_ok;
  logic       unused_rsrc;

  assign op   = instr[15:12];
  assign cond = instr[11:8];
  assign ext  = instr[7:4];
  // Rsrc/imm is consumed by the datapath, never by the controller.
  assign unused_rsrc = ^instr[3:0];

  // R-type forms carry the ALU function in ext; everything else in op.
  assign alu_code = (op == OP_RTYPE) ? ext : op;

`ifdef MEM_READY_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  cr16_cond_eval u_cond_eval (
    .cond      (cond),
    .flags     (flags),
    .cond_true (cond_true)
  );

  // State register and transitions. Reset wins over every transition,
  // including the memory wait states.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      case (state_reg)
        S_FETCH:  if (mem_ok) state_reg <= S_DECODE;
        S_DECODE: state_reg <= dispatch(op, ext);
        S_MEM_RD: if (mem_ok) state_reg <= S_MEM_WB;
        S_MEM_WR: if (mem_ok) state_reg <= S_FETCH;
        S_EX_R, S_EX_I, S_EX_SH,
        S_MEM_WB, S_BRANCH, S_JUMP, S_TRAP: state_reg <= S_FETCH;
        default:  state_reg <= S_FETCH;
      endcase
    end
  end

  // Output decode from the state register and the (already registered) IR.
  // This is combinational rather than a second register stage because the
  // enables must drop in the very cycle reset is seen and, with the ready
  // handshake, must track mem_ready within the same cycle.
  always_comb begin
    ir_en    = 1'b0;
    pcen     = 1'b0;
    pc_s     = PC_INC;
    adr_s    = 1'b0;
    mem_we   = 1'b0;
    regwrite = 1'b0;
    wa_s     = 1'b0;
    wd_s     = WD_ALU;
    alua_s   = ALUA_RDEST;
    shft_s   = 1'b0;
    imm_sext = 1'b0;
    alu_op   = 4'd0;
    psr_en   = 1'b0;
    illegal  = 1'b0;

    case (state_reg)
      S_FETCH: begin
        adr_s = 1'b0;
        ir_en = mem_ok;
        pcen  = mem_ok;
        pc_s  = PC_INC;
      end

      S_EX_R, S_EX_I, S_EX_SH: begin
        alu_op   = alu_code;
        // Compares only set flags; the result is discarded.
        regwrite = (alu_code != OP_CMP);
        wa_s     = 1'b0;
        wd_s     = WD_ALU;
        psr_en   = sets_psr(alu_code);
        // MOV and LUI pass operand B through, so A is forced to zero.
        alua_s   = ((alu_code == OP_MOV) || (alu_code == OP_LUI)) ? ALUA_ZERO
                                                                  : ALUA_RDEST;
        // Immediate and shift forms take B from the immediate field.
        shft_s   = (state_reg != S_EX_R);
        imm_sext = ~is_logical(op);
      end

      S_MEM_RD: begin
        adr_s = 1'b1;
      end

      S_MEM_WB: begin
        regwrite = 1'b1;
        wd_s     = WD_MEM;
      end

      S_MEM_WR: begin
        adr_s  = 1'b1;
        mem_we = mem_ok;
      end

      S_BRANCH: begin
        pcen = cond_true;
        pc_s = PC_DISP;
      end

      S_JUMP: begin
        pcen = cond_true;
        pc_s = PC_REG;
        // The link is written whether or not the jump is taken.
        if (ext == EXT_JAL) begin
          regwrite = 1'b1;
          wd_s     = WD_LINK;
        end
      end

      S_TRAP: begin
        illegal = 1'b1;
      end

      default: begin
      end
    endcase

    // While reset is asserted nothing may be written; FETCH still loads IR.
    if (reset) begin
      ir_en    = (state_reg == S_FETCH) && mem_ok;
      pcen     = 1'b0;
      pc_s     = PC_INC;
      adr_s    = 1'b0;
      mem_we   = 1'b0;
      regwrite = 1'b0;
      wa_s     = 1'b0;
      wd_s     = WD_ALU;
      alua_s   = ALUA_RDEST;
      shft_s   = 1'b0;
      imm_sext = 1'b0;
      alu_op   = 4'd0;
      psr_en   = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule
